// File: rtl/bmem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a 64-bit burst memory: line reads, 4-beat writes, read merge and write hazard stall.
// Optional perf counters are built only when BMEM_ARB_PERF_EN is defined.
module bmem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         p0_read,
  input  logic         p0_write,
  input  logic [31:0]  p0_addr,
  input  logic [255:0] p0_wdata,
  output logic         p0_resp,
  output logic [255:0] p0_rdata,
  input  logic         p1_read,
  input  logic         p1_write,
  input  logic [31:0]  p1_addr,
  input  logic [255:0] p1_wdata,
  output logic         p1_resp,
  output logic [255:0] p1_rdata,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic         bmem_rvalid,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata
`ifdef BMEM_ARB_PERF_EN
  ,
  output logic [31:0]  perf_rd,
  output logic [31:0]  perf_wr,
  output logic [31:0]  perf_stall
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RD_ISSUE = 2'd1;
  localparam logic [1:0] S_WR_BEAT  = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_wbeat;
  logic         r_port;
  logic [31:0]  r_addr;
  logic [255:0] r_wdata;
  logic [1:0]   r_pend_vld;
  logic [31:0]  r_pend_addr [2];
  logic         r_rr;
  logic         r_go;
  logic [1:0]   r_rbeat;
  logic [191:0] r_rbuf;
  logic         r_rarm;
  logic [1:0]   r_resp;
  logic [255:0] r_rdata [2];

  logic [1:0]   w_rd;
  logic [1:0]   w_wr;
  logic [31:0]  w_addr [2];
  logic [255:0] w_wdata [2];
  logic [1:0]   w_hazard;
  logic [1:0]   w_merge;
  logic [1:0]   w_elig;
  logic [1:0]   w_hit;
  logic         w_rbeat_v;
  logic         w_last_beat;
  logic         w_gnt_vld;
  logic         w_gnt;
  logic         w_gnt_rd;
  logic         w_gnt_merge;
  logic         w_rd_done;
  logic         w_wr_done;

  assign w_rd       = {p1_read, p0_read};
  assign w_wr       = {p1_write, p0_write};
  assign w_addr[0]  = p0_addr;
  assign w_addr[1]  = p1_addr;
  assign w_wdata[0] = p0_wdata;
  assign w_wdata[1] = p1_wdata;

  // Beats seen right after reset belong to an abandoned burst until rvalid has been low once.
  assign w_rbeat_v   = bmem_rvalid && r_rarm;
  assign w_last_beat = w_rbeat_v && (r_rbeat == 2'd3);

  for (genvar g = 0; g < 2; g++) begin : g_port
    assign w_hazard[g] = (r_pend_vld[0] && (r_pend_addr[0] == w_addr[g])) ||
                         (r_pend_vld[1] && (r_pend_addr[1] == w_addr[g]));
    assign w_merge[g]  = r_pend_vld[1-g] && (r_pend_addr[1-g] == w_addr[g]);
    assign w_elig[g]   = (w_rd[g] || (w_wr[g] && !w_hazard[g])) && !r_pend_vld[g] && !r_resp[g];
    assign w_hit[g]    = w_last_beat && r_pend_vld[g] && (r_pend_addr[g] == bmem_raddr);
  end

  // No grant on a burst's final beat, so a merge can never slip past the returning data.
  assign w_gnt_vld   = (r_state == S_IDLE) && r_go && !w_last_beat && (|w_elig);
  assign w_gnt       = w_elig[r_rr] ? r_rr : ~r_rr;
  assign w_gnt_rd    = w_rd[w_gnt];
  assign w_gnt_merge = w_gnt_rd && w_merge[w_gnt];
  assign w_rd_done   = (r_state == S_RD_ISSUE) && bmem_ready;
  assign w_wr_done   = (r_state == S_WR_BEAT) && bmem_ready && (r_wbeat == 2'd3);

  assign bmem_read  = (r_state == S_RD_ISSUE);
  assign bmem_write = (r_state == S_WR_BEAT) && (r_wbeat == 2'd0);
  assign bmem_addr  = (r_state != S_IDLE) ? r_addr : 32'd0;
  assign bmem_wdata = (r_state == S_WR_BEAT) ? r_wdata[{r_wbeat, 6'd0} +: 64] : 64'd0;

  assign p0_resp  = r_resp[0];
  assign p1_resp  = r_resp[1];
  assign p0_rdata = r_rdata[0];
  assign p1_rdata = r_rdata[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_wbeat        <= 2'd0;
      r_port         <= 1'b0;
      r_addr         <= 32'd0;
      r_wdata        <= 256'd0;
      r_pend_vld     <= 2'b00;
      r_pend_addr[0] <= 32'd0;
      r_pend_addr[1] <= 32'd0;
      r_rr           <= 1'b0;
      r_go           <= 1'b0;
      r_resp         <= 2'b00;
    end else begin
      r_go   <= 1'b1;
      r_resp <= w_hit;
      if (w_wr_done) r_resp[r_port] <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_rr <= ~w_gnt;
            if (w_gnt_merge) begin
              r_pend_vld[w_gnt]  <= 1'b1;
              r_pend_addr[w_gnt] <= w_addr[w_gnt];
            end else begin
              r_port  <= w_gnt;
              r_addr  <= w_addr[w_gnt];
              r_wdata <= w_wdata[w_gnt];
              r_wbeat <= 2'd0;
              r_state <= w_gnt_rd ? S_RD_ISSUE : S_WR_BEAT;
            end
          end
        end
        S_RD_ISSUE: begin
          if (bmem_ready) begin
            r_pend_vld[r_port]  <= 1'b1;
            r_pend_addr[r_port] <= r_addr;
            r_state             <= S_IDLE;
          end
        end
        S_WR_BEAT: begin
          if (bmem_ready) begin
            r_wbeat <= r_wbeat + 2'd1;
            if (r_wbeat == 2'd3) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_hit[0]) r_pend_vld[0] <= 1'b0;
      if (w_hit[1]) r_pend_vld[1] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbeat    <= 2'd0;
      r_rbuf     <= 192'd0;
      r_rarm     <= 1'b0;
      r_rdata[0] <= 256'd0;
      r_rdata[1] <= 256'd0;
    end else begin
      r_rarm <= r_rarm | ~bmem_rvalid;
      if (w_rbeat_v) begin
        r_rbeat <= r_rbeat + 2'd1;
        case (r_rbeat)
          2'd0:    r_rbuf[63:0]    <= bmem_rdata;
          2'd1:    r_rbuf[127:64]  <= bmem_rdata;
          2'd2:    r_rbuf[191:128] <= bmem_rdata;
          default: ;
        endcase
      end
      if (w_hit[0]) r_rdata[0] <= {bmem_rdata, r_rbuf};
      if (w_hit[1]) r_rdata[1] <= {bmem_rdata, r_rbuf};
    end
  end

`ifdef BMEM_ARB_PERF_EN
  logic [1:0] w_hzwait;
  logic       w_stall;

  assign w_hzwait = w_wr & ~w_rd & w_hazard & ~r_pend_vld & ~r_resp;
  assign w_stall  = ((r_state != S_IDLE) && !bmem_ready) || ((r_state == S_IDLE) && (|w_hzwait));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd    <= 32'd0;
      perf_wr    <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      if (w_rd_done) perf_rd    <= perf_rd + 32'd1;
      if (w_wr_done) perf_wr    <= perf_wr + 32'd1;
      if (w_stall)   perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
